// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its watchdog.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int PC_INC = 1;
  localparam int WDOG_W = 8;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus: address/read strobe out, data plus MFC completion back.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] ROM_Address;
  logic              ROM_Read;
  logic [31:0]       ROM_Data;
  logic              MFC;

  modport master (output ROM_Address, ROM_Read, input ROM_Data, MFC);
  modport slave  (input ROM_Address, ROM_Read, output ROM_Data, MFC);

endinterface

// File: rtl/mfc_watchdog.sv
// Counts WAIT cycles spent without MFC; terminal flags the last permitted cycle.
module mfc_watchdog
  import fetch_pkg::*;
#(
  parameter int MFC_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [WDOG_W-1:0] TERMINAL = WDOG_W'(MFC_TIMEOUT - 1);

  logic [WDOG_W-1:0] r_count;

  // Saturates at terminal so an idle-but-enabled counter never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_terminal) begin
      r_count <= r_count + WDOG_W'(1);
    end
  end

  assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, runs the MFC read handshake, loads IR and
// advances the PC by increment, branch offset or jump target.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                MFC_TIMEOUT = 16
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Fetch_Start,
  input  logic                    i_Stall,
  input  logic                    i_PC_Select,
  input  logic                    i_INC_Select,
  input  logic [ADDR_W-1:0]       i_BranchOffset,
  input  logic [ADDR_W-1:0]       i_RA_In,
  instruction_fetch_unit_if.master rom,
  output logic [31:0]             o_IR_Out,
  output logic [ADDR_W-1:0]       o_PC_Out,
  output logic [ADDR_W-1:0]       o_PC_Temp,
  output logic                    o_Instr_Valid,
  output logic                    o_Busy,
  output logic                    o_Fetch_Fault
);

  fetch_state_t      r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, r_pc_temp, r_offset, r_ra, w_next_pc;
  logic [31:0]       r_ir;
  logic              r_pc_sel, r_inc_sel, r_valid;
  logic              w_accept, w_complete, w_wd_clear, w_wd_enable, w_wd_terminal;

  mfc_watchdog #(.MFC_TIMEOUT(MFC_TIMEOUT)) u_watchdog (
    .i_clk      (i_Clock),
    .i_rst      (i_Reset),
    .i_clear    (w_wd_clear),
    .i_enable   (w_wd_enable),
    .o_terminal (w_wd_terminal)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // MFC has priority over the timeout, so a completion on the last WAIT cycle still succeeds.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_wd_clear   = 1'b0;
    w_wd_enable  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_Fetch_Start && !i_Stall) begin
          w_accept     = 1'b1;
          w_next_state = REQ;
        end
      end
      REQ: begin
        w_wd_clear   = 1'b1;
        w_next_state = WAIT;
      end
      WAIT: begin
        if (rom.MFC) begin
          w_complete   = 1'b1;
          w_next_state = IDLE;
        end else if (w_wd_terminal) begin
          w_next_state = FAULT;
        end else begin
          w_wd_enable = 1'b1;
        end
      end
      FAULT:   w_next_state = FAULT;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_next_pc = r_pc_sel ? (r_pc + (r_inc_sel ? r_offset : ADDR_W'(PC_INC))) : r_ra;

  // Selects are captured at acceptance so later input changes cannot redirect this fetch.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_pc_temp <= '0;
      r_valid   <= 1'b0;
      r_pc_sel  <= 1'b0;
      r_inc_sel <= 1'b0;
      r_offset  <= '0;
      r_ra      <= '0;
    end else begin
      r_valid <= w_complete;
      if (w_accept) begin
        r_pc_sel  <= i_PC_Select;
        r_inc_sel <= i_INC_Select;
        r_offset  <= i_BranchOffset;
        r_ra      <= i_RA_In;
      end
      if (w_complete) begin
        r_ir      <= rom.ROM_Data;
        r_pc_temp <= r_pc + ADDR_W'(PC_INC);
        r_pc      <= w_next_pc;
      end
    end
  end

  assign rom.ROM_Address = r_pc;
  assign rom.ROM_Read    = (r_state == REQ) || (r_state == WAIT);
  assign o_IR_Out        = r_ir;
  assign o_PC_Out        = r_pc;
  assign o_PC_Temp       = r_pc_temp;
  assign o_Instr_Valid   = r_valid;
  assign o_Busy          = (r_state != IDLE);
  assign o_Fetch_Fault   = (r_state == FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table,
// multi-cycle corner sequences and randomized fetches against a PC model.
module tb_instruction_fetch_unit;

  localparam int ADDR_W      = 32;
  localparam int MFC_TIMEOUT = 16;

  logic        i_Clock, i_Reset, i_Fetch_Start, i_Stall, i_PC_Select, i_INC_Select;
  logic [31:0] i_BranchOffset, i_RA_In;
  logic [31:0] o_IR_Out, o_PC_Out, o_PC_Temp;
  logic        o_Instr_Valid, o_Busy, o_Fetch_Fault;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastIr, pcModel, startPc;

  typedef struct {
    logic        pcSel;
    logic        incSel;
    logic [31:0] offset;
    logic [31:0] ra;
    logic [31:0] raAfter;
    int          delay;
    bit          backToBack;
    logic [31:0] expPc;
    logic [31:0] expTemp;
  } vec_t;

  vec_t vecs[8];

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) romBus();

  instruction_fetch_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (32'h0),
    .MFC_TIMEOUT (MFC_TIMEOUT)
  ) dut (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Fetch_Start  (i_Fetch_Start),
    .i_Stall        (i_Stall),
    .i_PC_Select    (i_PC_Select),
    .i_INC_Select   (i_INC_Select),
    .i_BranchOffset (i_BranchOffset),
    .i_RA_In        (i_RA_In),
    .rom            (romBus),
    .o_IR_Out       (o_IR_Out),
    .o_PC_Out       (o_PC_Out),
    .o_PC_Temp      (o_PC_Temp),
    .o_Instr_Valid  (o_Instr_Valid),
    .o_Busy         (o_Busy),
    .o_Fetch_Fault  (o_Fetch_Fault)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] time limit exceeded");
  end

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] romWord(input logic [31:0] addr);
    if (addr == 32'h0) return 32'hA5A5_0001;
    return (addr * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic doReset();
    i_Reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_pc", o_PC_Out, 32'h0);
    checkOutput("reset_rom_address", romBus.ROM_Address, 32'h0);
    checkOutput("reset_ir", o_IR_Out, 32'h0);
    checkOutput("reset_pc_temp", o_PC_Temp, 32'h0);
    checkFlag("reset_rom_read", romBus.ROM_Read, 1'b0);
    checkFlag("reset_valid", o_Instr_Valid, 1'b0);
    checkFlag("reset_busy", o_Busy, 1'b0);
    checkFlag("reset_fault", o_Fetch_Fault, 1'b0);
    i_Reset = 1'b0;
  endtask

  // One complete fetch starting in an IDLE cycle; ends in the Instr_Valid cycle.
  task automatic applyStimulus(input logic pcSel, input logic incSel, input logic [31:0] off,
                               input logic [31:0] ra, input logic [31:0] raAfter, input int delay,
                               input logic [31:0] fromPc, input logic [31:0] expPc,
                               input logic [31:0] expTemp);
    logic [31:0] word;
    word = romWord(fromPc);
    checkFlag("idle_rom_read", romBus.ROM_Read, 1'b0);
    checkOutput("idle_rom_address", romBus.ROM_Address, fromPc);
    i_Fetch_Start  = 1'b1;
    i_Stall        = 1'b0;
    i_PC_Select    = pcSel;
    i_INC_Select   = incSel;
    i_BranchOffset = off;
    i_RA_In        = ra;
    tick();
    i_Fetch_Start   = 1'($urandom_range(0, 1));
    i_Stall         = 1'($urandom_range(0, 1));
    i_PC_Select     = ~pcSel;
    i_INC_Select    = ~incSel;
    i_BranchOffset  = $urandom;
    i_RA_In         = raAfter;
    romBus.MFC      = 1'($urandom_range(0, 1));
    romBus.ROM_Data = $urandom;
    checkFlag("req_rom_read", romBus.ROM_Read, 1'b1);
    checkFlag("req_busy", o_Busy, 1'b1);
    checkFlag("req_valid", o_Instr_Valid, 1'b0);
    tick();
    romBus.MFC = 1'b0;
    checkFlag("wait_rom_read", romBus.ROM_Read, 1'b1);
    for (int k = 0; k < delay; k++) tick();
    checkFlag("wait_late_rom_read", romBus.ROM_Read, 1'b1);
    checkFlag("wait_late_fault", o_Fetch_Fault, 1'b0);
    romBus.MFC      = 1'b1;
    romBus.ROM_Data = word;
    i_Fetch_Start   = 1'b0;
    tick();
    romBus.MFC      = 1'b0;
    romBus.ROM_Data = $urandom;
    checkOutput("done_ir", o_IR_Out, word);
    checkOutput("done_pc", o_PC_Out, expPc);
    checkOutput("done_pc_temp", o_PC_Temp, expTemp);
    checkFlag("done_valid", o_Instr_Valid, 1'b1);
    checkFlag("done_rom_read", romBus.ROM_Read, 1'b0);
    checkFlag("done_busy", o_Busy, 1'b0);
    lastIr = word;
  endtask

  initial begin
    logic        pcSel, incSel;
    logic [31:0] off, ra, expPc;

    vecs[0] = '{1'b1, 1'b0, 32'h0,         32'h0,         32'h0,  0,  1'b0, 32'h1,         32'h1};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         32'h5,         32'h77, 3,  1'b0, 32'h5,         32'h2};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFE, 32'h0,         32'h0,  1,  1'b1, 32'h3,         32'h6};
    vecs[3] = '{1'b0, 1'b1, 32'h0,         32'hFFFF_FFFF, 32'h0,  0,  1'b0, 32'hFFFF_FFFF, 32'h4};
    vecs[4] = '{1'b1, 1'b0, 32'h0,         32'h0,         32'h0,  2,  1'b1, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         32'h8,         32'h0,  0,  1'b0, 32'h8,         32'h1};
    vecs[6] = '{1'b0, 1'b0, 32'h0,         32'h40,        32'h99, 0,  1'b0, 32'h40,        32'h9};
    vecs[7] = '{1'b1, 1'b1, 32'h10,        32'h0,         32'h0,  15, 1'b0, 32'h50,        32'h41};

    i_Fetch_Start   = 1'b0;
    i_Stall         = 1'b0;
    i_PC_Select     = 1'b1;
    i_INC_Select    = 1'b0;
    i_BranchOffset  = 32'h0;
    i_RA_In         = 32'h0;
    romBus.MFC      = 1'b0;
    romBus.ROM_Data = 32'h0;
    lastIr          = 32'h0;
    doReset();

    $display("[TB] stall blocks acceptance");
    i_Fetch_Start = 1'b1;
    i_Stall       = 1'b1;
    repeat (3) begin
      tick();
      checkFlag("stall_rom_read", romBus.ROM_Read, 1'b0);
      checkFlag("stall_busy", o_Busy, 1'b0);
    end
    i_Fetch_Start = 1'b0;
    i_Stall       = 1'b0;

    $display("[TB] directed vector table");
    startPc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pcSel, vecs[i].incSel, vecs[i].offset, vecs[i].ra, vecs[i].raAfter,
                    vecs[i].delay, startPc, vecs[i].expPc, vecs[i].expTemp);
      startPc = vecs[i].expPc;
      if (!vecs[i].backToBack) begin
        tick();
        checkFlag("valid_pulse_width", o_Instr_Valid, 1'b0);
      end
    end

    $display("[TB] reset during WAIT");
    i_Fetch_Start = 1'b1;
    tick();
    i_Fetch_Start = 1'b0;
    tick();
    tick();
    i_Reset = 1'b1;
    tick();
    checkOutput("midreset_pc", o_PC_Out, 32'h0);
    checkOutput("midreset_ir", o_IR_Out, 32'h0);
    checkOutput("midreset_pc_temp", o_PC_Temp, 32'h0);
    checkFlag("midreset_rom_read", romBus.ROM_Read, 1'b0);
    checkFlag("midreset_busy", o_Busy, 1'b0);
    i_Reset         = 1'b0;
    romBus.MFC      = 1'b1;
    romBus.ROM_Data = 32'hDEAD_BEEF;
    tick();
    romBus.MFC = 1'b0;
    checkOutput("late_mfc_ir", o_IR_Out, 32'h0);
    checkFlag("late_mfc_valid", o_Instr_Valid, 1'b0);
    checkOutput("late_mfc_pc", o_PC_Out, 32'h0);
    pcModel = 32'h0;
    lastIr  = 32'h0;

    $display("[TB] randomized fetches");
    for (int n = 0; n < 40; n++) begin
      pcSel  = 1'($urandom_range(0, 1));
      incSel = 1'($urandom_range(0, 1));
      off    = (n % 3 == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
      ra     = $urandom;
      if (!pcSel)      expPc = ra;
      else if (incSel) expPc = pcModel + off;
      else             expPc = pcModel + 32'd1;
      if ($urandom_range(0, 2) == 0) begin
        i_Fetch_Start = 1'b1;
        i_Stall       = 1'b1;
        tick();
        checkFlag("rand_stall_busy", o_Busy, 1'b0);
        i_Fetch_Start = 1'b0;
      end
      applyStimulus(pcSel, incSel, off, ra, $urandom, int'($urandom_range(0, 15)),
                    pcModel, expPc, pcModel + 32'd1);
      pcModel = expPc;
      if ($urandom_range(0, 1) == 1) begin
        tick();
        checkFlag("rand_valid_width", o_Instr_Valid, 1'b0);
      end
    end

    $display("[TB] MFC timeout fault");
    i_Fetch_Start = 1'b1;
    i_Stall       = 1'b0;
    tick();
    i_Fetch_Start = 1'b0;
    romBus.MFC    = 1'b0;
    tick();
    for (int k = 1; k < MFC_TIMEOUT; k++) tick();
    checkFlag("last_wait_rom_read", romBus.ROM_Read, 1'b1);
    checkFlag("last_wait_fault", o_Fetch_Fault, 1'b0);
    tick();
    checkFlag("fault_flag", o_Fetch_Fault, 1'b1);
    checkFlag("fault_rom_read", romBus.ROM_Read, 1'b0);
    checkFlag("fault_busy", o_Busy, 1'b1);
    checkOutput("fault_pc", o_PC_Out, pcModel);
    i_Fetch_Start   = 1'b1;
    romBus.MFC      = 1'b1;
    romBus.ROM_Data = 32'h1234_5678;
    repeat (4) tick();
    checkFlag("fault_sticky", o_Fetch_Fault, 1'b1);
    checkFlag("fault_no_valid", o_Instr_Valid, 1'b0);
    checkFlag("fault_still_busy", o_Busy, 1'b1);
    checkFlag("fault_no_read", romBus.ROM_Read, 1'b0);
    checkOutput("fault_pc_held", o_PC_Out, pcModel);
    checkOutput("fault_ir_held", o_IR_Out, lastIr);
    i_Fetch_Start = 1'b0;
    romBus.MFC    = 1'b0;
    doReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that feeds the control signal generator and decode logic.
- Holds the program counter and issues an instruction-memory read with an MFC (memory-function-complete) handshake.
- Loads the fetched word into the instruction register and computes the next PC (increment, branch offset, or jump to RA).
- Pulses Instr_Valid so the step counter and control generator may advance into decode.

Parameters:
- ADDR_W, 32, width of PC, ROM address, BranchOffset, RA_In.
- RESET_PC, 0, PC value after reset (word address).
- MFC_TIMEOUT, 16, number of WAIT cycles without MFC before a fault is declared; legal range 1..255.

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  synchronous, active-high reset
Fetch_Start  input  1  request one fetch (stage-0 pulse from step counter)
Stall  input  1  blocks acceptance of Fetch_Start
PC_Select  input  1  0: next PC = RA_In; 1: next PC = PC + increment
INC_Select  input  1  0: increment = 1; 1: increment = BranchOffset
BranchOffset  input  ADDR_W  two's-complement branch offset
RA_In  input  ADDR_W  jump/return target
ROM_Address  output  ADDR_W  instruction memory address, always equals PC_Out
ROM_Read  output  1  read strobe to instruction memory
ROM_Data  input  32  instruction word from memory
MFC  input  1  memory function complete; ROM_Data valid this cycle
IR_Out  output  32  instruction register
PC_Out  output  ADDR_W  current PC
PC_Temp  output  ADDR_W  link value: address of fetched instruction + 1
Instr_Valid  output  1  one-cycle pulse, IR_Out newly loaded
Busy  output  1  high whenever state is not IDLE
Fetch_Fault  output  1  sticky MFC timeout flag

Behaviour:
- Reset values:
  - PC_Out = RESET_PC, so ROM_Address = RESET_PC.
  - IR_Out = 0, PC_Temp = 0.
  - ROM_Read = 0, Instr_Valid = 0, Busy = 0, Fetch_Fault = 0.
  - State = IDLE, watchdog = 0.
- Reset takes effect at the clock edge, in any state, including mid-transaction.
- States: IDLE, REQ, WAIT, FAULT.
- IDLE:
  - If Fetch_Start=1 and Stall=0, latch PC_Select, INC_Select, BranchOffset and RA_In, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - ROM_Read=1 (address settle cycle).
  - MFC is ignored in this state.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - ROM_Read=1.
  - If MFC=1 on a clock edge:
    - IR_Out <= ROM_Data.
    - PC_Temp <= PC_Out+1.
    - PC_Out <= next PC, computed from the latched selects.
    - Instr_Valid <= 1 for exactly the next cycle.
    - Go to IDLE.
  - Else, if the watchdog equals MFC_TIMEOUT-1, go to FAULT.
  - Else, increment the watchdog.
- FAULT:
  - ROM_Read=0 and Fetch_Fault=1.
  - PC_Out and IR_Out are held.
  - Fetch_Start is ignored; only Reset exits this state.
- Next PC:
  - PC_Select=0: RA_In.
  - PC_Select=1 with INC_Select=0: PC_Out + 1.
  - PC_Select=1 with INC_Select=1: PC_Out + BranchOffset.
  - Addition is modulo 2^ADDR_W; wrap-around is silent.
- Latency: Fetch_Start sampled at cycle t → REQ at t+1 → earliest MFC at t+2 → IR_Out, PC_Out and Instr_Valid visible at t+3.
- Fetch_Start outside IDLE is ignored, with no queueing.
- Fetch_Start is accepted in the Instr_Valid cycle (state is IDLE), which allows back-to-back fetches.
- Stall affects only acceptance in IDLE. A transaction already in REQ or WAIT always completes or faults.
- Latched selects and RA_In are used for the whole transaction. Input changes after acceptance have no effect.
- ROM_Data is sampled only on an MFC edge in WAIT.

Decomposition:
- Shared package fetch_pkg:
  - state enumeration: IDLE, REQ, WAIT, FAULT (2-bit).
  - PC_INC = 1.
  - watchdog counter width = 8.
- Sub-module mfc_watchdog:
  - Inputs: clear, enable.
  - Output: terminal count at MFC_TIMEOUT-1.
  - Synchronous reset.
- IR_Out, PC_Out and PC_Temp are plain registers inside this block.

Test Plan:
1. Reset; memory at 0 holds 32'hA5A5_0001; Fetch_Start at t (PC_Select=1, INC_Select=0); MFC at t+2 → at t+3: IR_Out=32'hA5A5_0001, PC_Out=1, PC_Temp=1, Instr_Valid=1 for exactly one cycle; ROM_Read high at t+1 and t+2 only.
2. Branch and wrap: PC=5, INC_Select=1, BranchOffset=32'hFFFF_FFFE → PC_Out=3. PC=32'hFFFF_FFFF with increment 1 → PC_Out=0, PC_Temp=0.
3. Jump: PC=8, PC_Select=0, RA_In=32'h0000_0040, RA_In changed to 32'h99 after acceptance → PC_Out=32'h40, PC_Temp=9.
4. MFC never asserted, MFC_TIMEOUT=16 → Fetch_Fault=1 after 16 WAIT cycles, ROM_Read=0, PC_Out unchanged, later Fetch_Start ignored, Busy=1 until Reset.
5. Reset asserted in the second WAIT cycle, then MFC pulsed with ROM_Data=32'hDEAD_BEEF → PC_Out=RESET_PC, IR_Out=0, no Instr_Valid, ROM_Read=0 the cycle after reset.
6. Stall=1 with Fetch_Start → no ROM_Read and Busy stays 0. Fetch_Start during WAIT is ignored. Fetch_Start in the Instr_Valid cycle starts a second fetch, with REQ on the next cycle.
